// File: rtl/lsb_queue_param.sv
// In-order load/store queue: snoops ALU and its own write-back for operands, one op in flight to memory.
// Latency: head issues the cycle after it is ready, wb pulses the cycle after mem_resp_valid; dispatch dropped while full_out, request held until mem_req_ready.
module lsb_queue_param #(
    parameter int          DEPTH     = 8,
    parameter int          ROB_ADDR  = 4,
    parameter logic [31:0] IO_BASE   = 32'h30000,
    parameter bit          LOAD_SPEC = 1'b1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                disp_valid,
    input  logic [5:0]          disp_op,
    input  logic [ROB_ADDR-1:0] disp_robid,
    input  logic [31:0]         disp_val1,
    input  logic [31:0]         disp_val2,
    input  logic                disp_has_rely1,
    input  logic                disp_has_rely2,
    input  logic [ROB_ADDR-1:0] disp_rely1,
    input  logic [ROB_ADDR-1:0] disp_rely2,
    input  logic [31:0]         disp_imm,
    output logic                full_out,
    input  logic                alu_valid,
    input  logic [ROB_ADDR-1:0] alu_robid,
    input  logic [31:0]         alu_val,
    input  logic                rob_valid,
    input  logic [ROB_ADDR-1:0] rob_head_id,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_store,
    output logic [5:0]          mem_req_op,
    output logic [31:0]         mem_req_addr,
    output logic [31:0]         mem_req_data,
    input  logic                mem_resp_valid,
    input  logic [31:0]         mem_resp_data,
    output logic                wb_valid,
    output logic [ROB_ADDR-1:0] wb_robid,
    output logic [31:0]         wb_val
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [5:0]      OP_SB    = 6'd16;
    localparam logic [5:0]      OP_SW    = 6'd18;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    typedef struct packed {
        logic                vld;
        logic [5:0]          op;
        logic [ROB_ADDR-1:0] robid;
        logic                p1;
        logic [ROB_ADDR-1:0] t1;
        logic [31:0]         val1;
        logic                p2;
        logic [ROB_ADDR-1:0] t2;
        logic [31:0]         val2;
        logic [31:0]         imm;
    } ent_t;

    ent_t                q [DEPTH];
    ent_t                new_ent;
    logic [PW-1:0]       head, tail;
    logic [PW:0]         count;
    logic [1:0]          state;
    logic [ROB_ADDR-1:0] req_robid;

    logic        hd_vld, hd_ready, hd_store, hd_need_rob, can_issue, push, pop;
    logic [31:0] hd_addr;

    assign full_out    = (count == CNT_FULL);
    assign hd_vld      = q[head].vld;
    assign hd_ready    = !q[head].p1 && !q[head].p2;
    assign hd_addr     = q[head].val1 + q[head].imm;
    assign hd_store    = (q[head].op >= OP_SB) && (q[head].op <= OP_SW);
    // Stores and MMIO loads must not run ahead of the ROB head: they have side effects.
    assign hd_need_rob = hd_store || (hd_addr >= IO_BASE) || !LOAD_SPEC;
    assign can_issue   = hd_vld && hd_ready &&
                         (!hd_need_rob || (rob_valid && rob_head_id == q[head].robid));
    assign push        = disp_valid && !full_out && !flush_in;
    assign pop         = (state == S_REQ) && mem_req_ready && !flush_in;

    always_comb begin
        new_ent       = '0;
        new_ent.vld   = 1'b1;
        new_ent.op    = disp_op;
        new_ent.robid = disp_robid;
        new_ent.imm   = disp_imm;
        new_ent.p1    = disp_has_rely1;
        new_ent.t1    = disp_rely1;
        new_ent.val1  = disp_val1;
        new_ent.p2    = disp_has_rely2;
        new_ent.t2    = disp_rely2;
        new_ent.val2  = disp_val2;
        if (disp_has_rely1) begin
            if (alu_valid && alu_robid == disp_rely1) begin
                new_ent.p1   = 1'b0;
                new_ent.val1 = alu_val;
            end else if (wb_valid && wb_robid == disp_rely1) begin
                new_ent.p1   = 1'b0;
                new_ent.val1 = wb_val;
            end
        end
        if (disp_has_rely2) begin
            if (alu_valid && alu_robid == disp_rely2) begin
                new_ent.p2   = 1'b0;
                new_ent.val2 = alu_val;
            end else if (wb_valid && wb_robid == disp_rely2) begin
                new_ent.p2   = 1'b0;
                new_ent.val2 = wb_val;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q[i].vld && q[i].p1) begin
                        if (alu_valid && alu_robid == q[i].t1) begin
                            q[i].p1   <= 1'b0;
                            q[i].val1 <= alu_val;
                        end else if (wb_valid && wb_robid == q[i].t1) begin
                            q[i].p1   <= 1'b0;
                            q[i].val1 <= wb_val;
                        end
                    end
                    if (q[i].vld && q[i].p2) begin
                        if (alu_valid && alu_robid == q[i].t2) begin
                            q[i].p2   <= 1'b0;
                            q[i].val2 <= alu_val;
                        end else if (wb_valid && wb_robid == q[i].t2) begin
                            q[i].p2   <= 1'b0;
                            q[i].val2 <= wb_val;
                        end
                    end
                end
                if (pop) begin
                    q[head].vld <= 1'b0;
                    head        <= head + PTR_ONE;
                end
                if (push) begin
                    q[tail] <= new_ent;
                    tail    <= tail + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= S_IDLE;
            mem_req_valid <= 1'b0;
            mem_req_store <= 1'b0;
            mem_req_op    <= '0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            req_robid     <= '0;
            wb_valid      <= 1'b0;
            wb_robid      <= '0;
            wb_val        <= '0;
        end else if (rdy_in) begin
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!flush_in && can_issue) begin
                        state         <= S_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_store <= hd_store;
                        mem_req_op    <= q[head].op;
                        mem_req_addr  <= hd_addr;
                        mem_req_data  <= hd_store ? q[head].val2 : 32'h0;
                        req_robid     <= q[head].robid;
                    end
                end
                S_REQ: begin
                    if (flush_in) begin
                        state         <= S_IDLE;
                        mem_req_valid <= 1'b0;
                    end else if (mem_req_ready) begin
                        state         <= S_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A flushed op still owes the controller one response; swallow it.
                    if (flush_in) begin
                        state <= mem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (mem_resp_valid) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b1;
                        wb_robid <= req_robid;
                        wb_val   <= mem_req_store ? mem_req_addr : mem_resp_data;
                    end
                end
                S_DRAIN: begin
                    if (mem_resp_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
